// File: rtl/gmii_capture_writer.sv
// Captures one armed GMII frame into a RAM write port. The preamble and SFD are
// stripped, payload bytes are packed little-endian into DATA_WIDTH words, and frame status is reported.
module gmii_capture_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [7:0]            gmii_rxd,
  input  logic                  gmii_rx_dv,
  input  logic                  gmii_rx_er,
  output logic                  o_wr,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  truncated,
  output logic                  rx_error
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [7:0]          SFD       = 8'hD5;

  typedef enum logic [2:0] {IDLE, WAIT_GAP, WAIT_SFD, CAPTURE, FLUSH, DONE} state_e;

  state_e                state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] pack_q, pack_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  trunc_q, trunc_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] packed_word;
  logic                  full;

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      pack_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      words_q <= '0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      words_q <= words_d;
      trunc_q <= trunc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    len_d       = len_q;
    words_d     = words_q;
    trunc_d     = trunc_q;
    err_d       = err_q;
    full        = (words_q == CAPACITY);
    packed_word = pack_q;
    packed_word[{lane_q, 3'b000} +: 8] = gmii_rxd;

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = WAIT_GAP;
          len_d   = '0;
          words_d = '0;
          trunc_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      WAIT_GAP: begin
        if (!gmii_rx_dv) state_d = WAIT_SFD;
      end
      WAIT_SFD: begin
        if (gmii_rx_dv && gmii_rxd == SFD) begin
          state_d = CAPTURE;
          lane_d  = '0;
          pack_d  = '0;
        end
      end
      CAPTURE: begin
        if (gmii_rx_dv) begin
          if (len_q != '1) len_d = len_q + 1'b1;
          if (gmii_rx_er) err_d = 1'b1;
          // Once the RAM is full, bytes are only counted; the lane stays at 0 so nothing gets flushed.
          if (full) begin
            trunc_d = 1'b1;
          end else if (lane_q == LAST_LANE) begin
            wr_d    = 1'b1;
            addr_d  = words_q[ADDR_WIDTH-1:0];
            data_d  = packed_word;
            words_d = words_q + 1'b1;
            lane_d  = '0;
            pack_d  = '0;
          end else begin
            lane_d = lane_q + 1'b1;
            pack_d = packed_word;
          end
        end else if (lane_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = FLUSH;
          wr_d    = 1'b1;
          addr_d  = words_q[ADDR_WIDTH-1:0];
          data_d  = pack_q;
          words_d = words_q + 1'b1;
        end
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign o_wr          = wr_q;
  assign o_addr        = addr_q;
  assign o_data        = data_q;
  assign busy          = (state_q == WAIT_GAP) || (state_q == WAIT_SFD) ||
                         (state_q == CAPTURE)  || (state_q == FLUSH);
  assign done          = (state_q == DONE);
  assign frame_len     = len_q;
  assign words_written = words_q;
  assign truncated     = trunc_q;
  assign rx_error      = err_q;
endmodule

// File: tb/tb_gmii_capture_writer.sv
// Bench for gmii_capture_writer. It drives a default instance and an
// ADDR_WIDTH=2 instance in parallel and compares both against a frame-level reference model.
module tb_gmii_capture_writer;
  logic i_clk = 1'b0;
  logic rst, arm, dv, er;
  logic [7:0] rxd;
  always #5 i_clk = ~i_clk;

  logic wr0, busy0, done0, trunc0, err0;
  logic [7:0] addr0;
  logic [31:0] data0;
  logic [15:0] len0;
  logic [8:0] words0;
  logic wr1, busy1, done1, trunc1, err1;
  logic [1:0] addr1;
  logic [31:0] data1;
  logic [15:0] len1;
  logic [2:0] words1;

  gmii_capture_writer dut0 (
    .i_clk(i_clk), .rst(rst), .arm(arm), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .o_wr(wr0), .o_addr(addr0), .o_data(data0), .busy(busy0), .done(done0),
    .frame_len(len0), .words_written(words0), .truncated(trunc0), .rx_error(err0));

  gmii_capture_writer #(.ADDR_WIDTH(2)) dut1 (
    .i_clk(i_clk), .rst(rst), .arm(arm), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .o_wr(wr1), .o_addr(addr1), .o_data(data1), .busy(busy1), .done(done1),
    .frame_len(len1), .words_written(words1), .truncated(trunc1), .rx_error(err1));

  logic wrV[2], busyV[2], doneV[2], truncV[2], errV[2];
  logic [7:0] addrV[2];
  logic [31:0] dataV[2];
  logic [15:0] lenV[2];
  logic [8:0] wordsV[2];
  always_comb begin
    wrV[0] = wr0;     wrV[1] = wr1;
    busyV[0] = busy0; busyV[1] = busy1;
    doneV[0] = done0; doneV[1] = done1;
    truncV[0] = trunc0; truncV[1] = trunc1;
    errV[0] = err0;   errV[1] = err1;
    addrV[0] = addr0; addrV[1] = {6'b0, addr1};
    dataV[0] = data0; dataV[1] = data1;
    lenV[0] = len0;   lenV[1] = len1;
    wordsV[0] = words0; wordsV[1] = {6'b0, words1};
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Write log per instance, sampled just after each rising edge.
  int obsCnt[2];
  logic [7:0] obsAddr[2][0:1023];
  logic [31:0] obsData[2][0:1023];
  int obsCyc[2][0:1023];
  always begin
    @(posedge i_clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (wrV[d] === 1'b1) begin
        if (obsCnt[d] < 1024) begin
          obsAddr[d][obsCnt[d]] = addrV[d];
          obsData[d][obsCnt[d]] = dataV[d];
          obsCyc[d][obsCnt[d]]  = cyc;
        end
        obsCnt[d] = obsCnt[d] + 1;
      end
    end
  end

  logic [7:0] payload[$];
  logic erMask[$];
  logic [31:0] expWords[$];
  int byteCyc[0:63];
  int endCyc;
  int lastCyc;

  // Reference model: a frame's payload maps to ceil(n/4) little-endian words, zero padded.
  function automatic void build_expected();
    logic [31:0] word;
    expWords.delete();
    for (int w = 0; w * 4 < payload.size(); w++) begin
      word = '0;
      for (int b = 0; b < 4; b++)
        if (w * 4 + b < payload.size()) word = word | (32'(payload[w * 4 + b]) << (8 * b));
      expWords.push_back(word);
    end
  endfunction

  function automatic int capOf(int d);
    return (d == 0) ? 256 : 4;
  endfunction

  function automatic int expCount(int d);
    return (expWords.size() < capOf(d)) ? expWords.size() : capOf(d);
  endfunction

  function automatic logic expTrunc(int d);
    return payload.size() > capOf(d) * 4;
  endfunction

  function automatic logic expErr();
    logic r = 1'b0;
    foreach (erMask[i]) r = r | erMask[i];
    return r;
  endfunction

  function automatic int expCyc(int i);
    if (4 * i + 3 < payload.size()) return byteCyc[4 * i + 3] + 1;
    return endCyc + 1;
  endfunction

  task automatic drive_byte(input logic v, input logic [7:0] d, input logic e, input logic a);
    @(negedge i_clk);
    dv = v; rxd = d; er = e; arm = a;
    lastCyc = cyc;
  endtask

  task automatic random_payload(input int n, input bit withErr);
    payload.delete(); erMask.delete();
    for (int i = 0; i < n; i++) begin
      payload.push_back(8'($urandom));
      erMask.push_back(withErr && ($urandom_range(0, 15) == 0));
    end
  endtask

  task automatic run_frame(input bit doArm, input int pre, input int armAt);
    if (doArm) drive_byte(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) drive_byte(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < pre; i++) drive_byte(1'b1, 8'h55, 1'b0, 1'b0);
    drive_byte(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < payload.size(); i++) begin
      drive_byte(1'b1, payload[i], erMask[i], i == armAt);
      if (i < 64) byteCyc[i] = lastCyc;
    end
    drive_byte(1'b0, 8'h00, 1'b0, 1'b0);
    endCyc = lastCyc;
    repeat (4) drive_byte(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wrV[d], addrV[d], dataV[d], busyV[d], doneV[d], lenV[d], wordsV[d], truncV[d], errV[d]} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs dut%0d wr=%b addr=%h data=%h busy=%b done=%b len=%0d words=%0d trunc=%b err=%b exp=all zero",
                 d, wrV[d], addrV[d], dataV[d], busyV[d], doneV[d], lenV[d], wordsV[d], truncV[d], errV[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int base[2];
    payload.delete(); erMask.delete();
    for (int i = 0; i < 8; i++) begin payload.push_back(8'(i + 1)); erMask.push_back(1'b0); end
    build_expected();
    for (int d = 0; d < 2; d++) base[d] = obsCnt[d];
    run_frame(1'b1, 7, -1);
    for (int d = 0; d < 2; d++) begin
      int got, ec;
      got = obsCnt[d] - base[d]; ec = expCount(d);
      checks++; if (got != ec) begin failures++; $display("[TB] FAIL basic_wrcount dut%0d got=%0d exp=%0d", d, got, ec); end
      for (int i = 0; i < ec && i < got; i++) begin
        int k = base[d] + i;
        checks++;
        if (obsData[d][k] !== expWords[i] || obsAddr[d][k] !== 8'(i)) begin
          failures++; $display("[TB] FAIL basic_word%0d dut%0d got=%h@%0d exp=%h@%0d", i, d, obsData[d][k], obsAddr[d][k], expWords[i], i);
        end
        checks++;
        if (obsCyc[d][k] != expCyc(i)) begin
          failures++; $display("[TB] FAIL basic_latency%0d dut%0d got=%0d exp=%0d", i, d, obsCyc[d][k], expCyc(i));
        end
      end
      checks++; if (lenV[d] !== 16'(payload.size())) begin failures++; $display("[TB] FAIL basic_len dut%0d got=%0d exp=%0d", d, lenV[d], payload.size()); end
      checks++; if (wordsV[d] !== 9'(ec)) begin failures++; $display("[TB] FAIL basic_words dut%0d got=%0d exp=%0d", d, wordsV[d], ec); end
      checks++;
      if ({doneV[d], busyV[d], truncV[d], errV[d]} !== {1'b1, 1'b0, expTrunc(d), expErr()}) begin
        failures++; $display("[TB] FAIL basic_status dut%0d got=%b exp=%b", d, {doneV[d], busyV[d], truncV[d], errV[d]}, {1'b1, 1'b0, expTrunc(d), expErr()});
      end
    end
  endtask

  task automatic test_flush();
    int base[2];
    payload.delete(); erMask.delete();
    for (int i = 0; i < 6; i++) begin payload.push_back(8'hA1 + 8'(i)); erMask.push_back(1'b0); end
    build_expected();
    for (int d = 0; d < 2; d++) base[d] = obsCnt[d];
    run_frame(1'b1, 7, -1);
    for (int d = 0; d < 2; d++) begin
      int got, ec;
      got = obsCnt[d] - base[d]; ec = expCount(d);
      checks++; if (got != ec) begin failures++; $display("[TB] FAIL flush_wrcount dut%0d got=%0d exp=%0d", d, got, ec); end
      for (int i = 0; i < ec && i < got; i++) begin
        int k = base[d] + i;
        checks++;
        if (obsData[d][k] !== expWords[i] || obsAddr[d][k] !== 8'(i) || obsCyc[d][k] != expCyc(i)) begin
          failures++; $display("[TB] FAIL flush_word%0d dut%0d got=%h@%0d cyc=%0d exp=%h@%0d cyc=%0d", i, d, obsData[d][k], obsAddr[d][k], obsCyc[d][k], expWords[i], i, expCyc(i));
        end
      end
      checks++; if (lenV[d] !== 16'(payload.size()) || wordsV[d] !== 9'(ec)) begin
        failures++; $display("[TB] FAIL flush_counts dut%0d got len=%0d words=%0d exp len=%0d words=%0d", d, lenV[d], wordsV[d], payload.size(), ec);
      end
      checks++; if (doneV[d] !== 1'b1 || truncV[d] !== expTrunc(d)) begin
        failures++; $display("[TB] FAIL flush_status dut%0d got done=%b trunc=%b exp done=1 trunc=%b", d, doneV[d], truncV[d], expTrunc(d));
      end
    end
  endtask

  task automatic test_arm_midframe();
    int base[2];
    random_payload(10, 1'b0);
    for (int d = 0; d < 2; d++) base[d] = obsCnt[d];
    repeat (2) drive_byte(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive_byte(1'b1, 8'h55, 1'b0, i == 2);
    drive_byte(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < payload.size(); i++) drive_byte(1'b1, payload[i], 1'b0, 1'b0);
    repeat (3) drive_byte(1'b0, 8'h00, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsCnt[d] != base[d] || busyV[d] !== 1'b1 || doneV[d] !== 1'b0 || lenV[d] !== 16'd0) begin
        failures++; $display("[TB] FAIL midframe_ignored dut%0d got writes=%0d busy=%b done=%b len=%0d exp writes=0 busy=1 done=0 len=0",
                             d, obsCnt[d] - base[d], busyV[d], doneV[d], lenV[d]);
      end
    end
    random_payload(11, 1'b0);
    build_expected();
    run_frame(1'b0, 5, -1);
    for (int d = 0; d < 2; d++) begin
      int got, ec;
      got = obsCnt[d] - base[d]; ec = expCount(d);
      checks++; if (got != ec) begin failures++; $display("[TB] FAIL midframe_wrcount dut%0d got=%0d exp=%0d", d, got, ec); end
      for (int i = 0; i < ec && i < got; i++) begin
        int k = base[d] + i;
        checks++;
        if (obsData[d][k] !== expWords[i] || obsAddr[d][k] !== 8'(i)) begin
          failures++; $display("[TB] FAIL midframe_word%0d dut%0d got=%h@%0d exp=%h@%0d", i, d, obsData[d][k], obsAddr[d][k], expWords[i], i);
        end
      end
      checks++; if (lenV[d] !== 16'(payload.size()) || wordsV[d] !== 9'(ec) || doneV[d] !== 1'b1) begin
        failures++; $display("[TB] FAIL midframe_stats dut%0d got len=%0d words=%0d done=%b exp len=%0d words=%0d done=1", d, lenV[d], wordsV[d], doneV[d], payload.size(), ec);
      end
    end
  endtask

  task automatic test_capacity();
    int base[2];
    random_payload(20, 1'b0);
    build_expected();
    for (int d = 0; d < 2; d++) base[d] = obsCnt[d];
    run_frame(1'b1, 7, -1);
    for (int d = 0; d < 2; d++) begin
      int got, ec;
      got = obsCnt[d] - base[d]; ec = expCount(d);
      checks++; if (got != ec) begin failures++; $display("[TB] FAIL capacity_wrcount dut%0d got=%0d exp=%0d", d, got, ec); end
      for (int i = 0; i < ec && i < got; i++) begin
        int k = base[d] + i;
        checks++;
        if (obsData[d][k] !== expWords[i] || obsAddr[d][k] !== 8'(i)) begin
          failures++; $display("[TB] FAIL capacity_word%0d dut%0d got=%h@%0d exp=%h@%0d", i, d, obsData[d][k], obsAddr[d][k], expWords[i], i);
        end
      end
      checks++; if (truncV[d] !== expTrunc(d)) begin failures++; $display("[TB] FAIL capacity_trunc dut%0d got=%b exp=%b", d, truncV[d], expTrunc(d)); end
      checks++; if (lenV[d] !== 16'(payload.size()) || wordsV[d] !== 9'(ec)) begin
        failures++; $display("[TB] FAIL capacity_counts dut%0d got len=%0d words=%0d exp len=%0d words=%0d", d, lenV[d], wordsV[d], payload.size(), ec);
      end
    end
  endtask

  task automatic test_rx_error();
    int base[2];
    random_payload(12, 1'b0);
    erMask[3] = 1'b1;
    build_expected();
    for (int d = 0; d < 2; d++) base[d] = obsCnt[d];
    run_frame(1'b1, 7, 5);
    for (int d = 0; d < 2; d++) begin
      int got, ec;
      got = obsCnt[d] - base[d]; ec = expCount(d);
      checks++; if (got != ec) begin failures++; $display("[TB] FAIL rxerr_wrcount dut%0d got=%0d exp=%0d", d, got, ec); end
      for (int i = 0; i < ec && i < got; i++) begin
        int k = base[d] + i;
        checks++;
        if (obsData[d][k] !== expWords[i] || obsAddr[d][k] !== 8'(i)) begin
          failures++; $display("[TB] FAIL rxerr_word%0d dut%0d got=%h@%0d exp=%h@%0d", i, d, obsData[d][k], obsAddr[d][k], expWords[i], i);
        end
      end
      checks++; if (errV[d] !== 1'b1) begin failures++; $display("[TB] FAIL rxerr_flag dut%0d got=%b exp=1", d, errV[d]); end
      checks++; if (lenV[d] !== 16'(payload.size()) || doneV[d] !== 1'b1) begin
        failures++; $display("[TB] FAIL rxerr_busy_arm dut%0d got len=%0d done=%b exp len=%0d done=1", d, lenV[d], doneV[d], payload.size());
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base[2];
    for (int d = 0; d < 2; d++) base[d] = obsCnt[d];
    drive_byte(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) drive_byte(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive_byte(1'b1, 8'h55, 1'b0, 1'b0);
    drive_byte(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_byte(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    drive_byte(1'b1, 8'h15, 1'b0, 1'b0);
    rst = 1'b1;
    drive_byte(1'b1, 8'h16, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({wrV[d], addrV[d], dataV[d], busyV[d], doneV[d], lenV[d], wordsV[d], truncV[d], errV[d]} !== '0) begin
        failures++; $display("[TB] FAIL rstmid_outputs dut%0d wr=%b addr=%h data=%h busy=%b done=%b len=%0d words=%0d exp=all zero",
                             d, wrV[d], addrV[d], dataV[d], busyV[d], doneV[d], lenV[d], wordsV[d]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive_byte(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    repeat (3) drive_byte(1'b0, 8'h00, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsCnt[d] - base[d] != 1 || obsData[d][base[d]] !== 32'h13121110) begin
        failures++; $display("[TB] FAIL rstmid_writes dut%0d got count=%0d first=%h exp count=1 first=13121110", d, obsCnt[d] - base[d], obsData[d][base[d]]);
      end
      base[d] = obsCnt[d];
    end
    random_payload(9, 1'b0);
    build_expected();
    run_frame(1'b1, 3, -1);
    for (int d = 0; d < 2; d++) begin
      int got, ec;
      got = obsCnt[d] - base[d]; ec = expCount(d);
      checks++; if (got != ec) begin failures++; $display("[TB] FAIL rstmid_rearm_count dut%0d got=%0d exp=%0d", d, got, ec); end
      for (int i = 0; i < ec && i < got; i++) begin
        int k = base[d] + i;
        checks++;
        if (obsData[d][k] !== expWords[i] || obsAddr[d][k] !== 8'(i)) begin
          failures++; $display("[TB] FAIL rstmid_rearm_word%0d dut%0d got=%h@%0d exp=%h@%0d", i, d, obsData[d][k], obsAddr[d][k], expWords[i], i);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 12; iter++) begin
      int base[2];
      int n, prevN, armAt;
      n = $urandom_range(0, 40);
      random_payload(n, 1'b1);
      build_expected();
      armAt = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      for (int d = 0; d < 2; d++) base[d] = obsCnt[d];
      run_frame(1'b1, $urandom_range(1, 8), armAt);
      for (int d = 0; d < 2; d++) begin
        int got, ec;
        got = obsCnt[d] - base[d]; ec = expCount(d);
        checks++; if (got != ec) begin failures++; $display("[TB] FAIL rand%0d_wrcount dut%0d got=%0d exp=%0d", iter, d, got, ec); end
        for (int i = 0; i < ec && i < got; i++) begin
          int k = base[d] + i;
          checks++;
          if (obsData[d][k] !== expWords[i] || obsAddr[d][k] !== 8'(i) || obsCyc[d][k] != expCyc(i)) begin
            failures++; $display("[TB] FAIL rand%0d_word%0d dut%0d got=%h@%0d cyc=%0d exp=%h@%0d cyc=%0d", iter, i, d, obsData[d][k], obsAddr[d][k], obsCyc[d][k], expWords[i], i, expCyc(i));
          end
        end
        checks++;
        if (lenV[d] !== 16'(n) || wordsV[d] !== 9'(ec) || {doneV[d], busyV[d], truncV[d], errV[d]} !== {1'b1, 1'b0, expTrunc(d), expErr()}) begin
          failures++; $display("[TB] FAIL rand%0d_stats dut%0d got len=%0d words=%0d dbte=%b exp len=%0d words=%0d dbte=%b",
                               iter, d, lenV[d], wordsV[d], {doneV[d], busyV[d], truncV[d], errV[d]}, n, ec, {1'b1, 1'b0, expTrunc(d), expErr()});
        end
        base[d] = obsCnt[d];
      end
      // A second frame without re-arming must leave the capture untouched.
      prevN = n;
      random_payload($urandom_range(1, 20), 1'b0);
      run_frame(1'b0, $urandom_range(1, 8), -1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obsCnt[d] != base[d] || lenV[d] !== 16'(prevN) || doneV[d] !== 1'b1) begin
          failures++; $display("[TB] FAIL rand%0d_back_to_back dut%0d got writes=%0d len=%0d done=%b exp writes=0 len=%0d done=1",
                               iter, d, obsCnt[d] - base[d], lenV[d], doneV[d], prevN);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; dv = 1'b0; er = 1'b0; rxd = 8'h00;
    test_reset();
    test_basic();
    test_flush();
    test_arm_midframe();
    test_capacity();
    test_rx_error();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
